// File: rtl/parity_rx_pkg.sv
// rtl/parity_rx_pkg.sv - shared FSM state encoding and error-counter constants for parity_frame_rx
package parity_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } rx_state_t;

    localparam int                    ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0]  ERR_SAT   = 8'd255;

endpackage

// File: rtl/parity_acc.sv
// rtl/parity_acc.sv - 1-bit running parity accumulator with load, clear and XOR update
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (acc -> 0)
//   i_clear    : synchronous clear (acc -> 0)
//   i_load     : load i_load_val (takes priority over clear and update)
//   i_load_val : value loaded at frame start (selects even/odd sense)
//   i_en       : XOR i_bit into the accumulator
//   i_bit      : data bit to fold in
//   o_acc      : current accumulator value
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_load_val,
    input  logic i_en,
    input  logic i_bit,
    output logic o_acc
);

    logic r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 1'b0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_clear) begin
            r_acc <= 1'b0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_bit;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial LSB-first frame receiver with trailing parity bit check
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-high reset
//   frame_start : one-cycle pulse starting (or restarting) a frame
//   bit_in      : serial data/parity bit
//   bit_valid   : qualifies bit_in
//   data_out    : data word of the last completed frame (first bit at LSB)
//   data_valid  : one-cycle pulse, the cycle after the parity bit is taken
//   parity_err  : 1 when the last completed frame failed its parity check
//   busy        : frame in progress (DATA or PAR)
//   err_count   : saturating count of frames completed with a parity error
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [DATA_W-1:0]    data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic              ACC_INIT = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    r_data_out;
    logic                 r_data_valid;
    logic                 r_parity_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic w_begin;
    logic w_shift;
    logic w_done;
    logic w_acc;
    logic w_par_err;

    // frame_start wins over everything, so a restart discards a bit arriving
    // in the same cycle and never completes the frame being abandoned.
    always_comb begin
        w_state_nxt = r_state;
        w_begin     = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        if (frame_start) begin
            w_state_nxt = ST_DATA;
            w_begin     = 1'b1;
        end else begin
            case (r_state)
                ST_DATA: begin
                    if (bit_valid) begin
                        w_shift = 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_state_nxt = ST_PAR;
                        end
                    end
                end
                ST_PAR: begin
                    if (bit_valid) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    parity_acc u_parity_acc (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_done),
        .i_load     (w_begin),
        .i_load_val (ACC_INIT),
        .i_en       (w_shift),
        .i_bit      (bit_in),
        .o_acc      (w_acc)
    );

    assign w_par_err = w_acc ^ bit_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_begin) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            // Shift in from the top so the first bit received ends at the LSB.
            r_shift <= {bit_in, r_shift[DATA_W-1:1]};
            r_cnt   <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_data_valid <= w_done;
            if (w_done) begin
                r_data_out   <= r_shift;
                r_parity_err <= w_par_err;
                if (w_par_err && (r_err_count != ERR_SAT)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign busy       = (r_state == ST_DATA) || (r_state == ST_PAR);
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - scoreboard bench for parity_frame_rx (even and odd instances)
module tb_parity_frame_rx;

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] data_e, data_o, cnt_e, cnt_o;
    logic       dv_e, dv_o, pe_e, pe_o, busy_e, busy_o;

    exp_t q_e[$];
    exp_t q_o[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   mcnt_e = 0;
    int   mcnt_o = 0;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(0)) u_even (
        .clk(clk), .reset(reset), .frame_start(frame_start), .bit_in(bit_in),
        .bit_valid(bit_valid), .data_out(data_e), .data_valid(dv_e),
        .parity_err(pe_e), .busy(busy_e), .err_count(cnt_e)
    );

    parity_frame_rx #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
        .clk(clk), .reset(reset), .frame_start(frame_start), .bit_in(bit_in),
        .bit_valid(bit_valid), .data_out(data_o), .data_valid(dv_o),
        .parity_err(pe_o), .busy(busy_o), .err_count(cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per data_valid pulse on each instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (dv_e) begin
                if (q_e.size() == 0) begin
                    chk("even_unexpected_data_valid", 1, 0);
                end else begin
                    exp_t x;
                    x = q_e.pop_front();
                    chk("even_data_out",   data_e, x.data);
                    chk("even_parity_err", pe_e,   x.err);
                    chk("even_err_count",  cnt_e,  x.cnt);
                end
            end
            if (dv_o) begin
                if (q_o.size() == 0) begin
                    chk("odd_unexpected_data_valid", 1, 0);
                end else begin
                    exp_t x;
                    x = q_o.pop_front();
                    chk("odd_data_out",   data_o, x.data);
                    chk("odd_parity_err", pe_o,   x.err);
                    chk("odd_err_count",  cnt_o,  x.cnt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    // The odd instance sees the same bits with the accumulator seeded to 1,
    // so its verdict is always the complement of the even one.
    task automatic push_exp(input logic [7:0] data, input logic err_even);
        exp_t x;
        if (err_even && mcnt_e < 255) mcnt_e++;
        if (!err_even && mcnt_o < 255) mcnt_o++;
        x.data = data; x.err = err_even;  x.cnt = 8'(mcnt_e);
        q_e.push_back(x);
        x.data = data; x.err = !err_even; x.cnt = 8'(mcnt_o);
        q_o.push_back(x);
    endtask

    // stream is written in send order: leftmost literal bit goes first.
    task automatic send_frame(input logic [7:0] stream, input logic par,
                              input logic [7:0] exp_data, input logic exp_err,
                              input int max_gap, input bit do_start, input bit chk_busy);
        if (do_start) start();
        for (int i = 7; i >= 0; i--) begin
            if (chk_busy) chk("busy_during_frame", busy_e, 1);
            send_bit(stream[i]);
            if (max_gap > 0) idle($urandom_range(max_gap, 0));
        end
        if (chk_busy) chk("busy_before_parity", busy_e, 1);
        push_exp(exp_data, exp_err);
        send_bit(par);
        if (chk_busy) begin
            chk("data_valid_latency", dv_e, 1);
            chk("busy_low_at_data_valid", busy_e, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_e"}, data_e, 0);
        chk({tag, "_dv_e"},   dv_e,   0);
        chk({tag, "_pe_e"},   pe_e,   0);
        chk({tag, "_busy_e"}, busy_e, 0);
        chk({tag, "_cnt_e"},  cnt_e,  0);
        chk({tag, "_data_o"}, data_o, 0);
        chk({tag, "_busy_o"}, busy_o, 0);
        chk({tag, "_cnt_o"},  cnt_o,  0);
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        idle(3);
        chk_all_zero("reset");
        reset = 1'b0;
        idle(2);

        // Bits without a frame_start are ignored.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        idle(2);
        chk_all_zero("stray_bits");

        // 1,0,1,0,0,1,0,1 -> 0xA5; four ones.
        send_frame(8'b10100101, 1'b0, 8'hA5, 1'b0, 0, 1'b1, 1'b1);
        idle(2);
        send_frame(8'b10100101, 1'b1, 8'hA5, 1'b1, 0, 1'b1, 1'b0);
        idle(2);
        // 0x3C with idle gaps between bits.
        send_frame(8'b00111100, 1'b0, 8'h3C, 1'b0, 5, 1'b1, 1'b1);
        idle(3);
        // First bit lands at the LSB: 1,1,0,... -> 0x03.
        send_frame(8'b11000000, 1'b0, 8'h03, 1'b0, 0, 1'b1, 1'b0);
        // Single one in the last slot -> 0x80, parity 0 is wrong for even.
        send_frame(8'b00000001, 1'b0, 8'h80, 1'b1, 1, 1'b1, 1'b0);
        idle(2);

        // Abort after 4 data bits, then a full 0xFF frame.
        start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_frame(8'b11111111, 1'b0, 8'hFF, 1'b0, 0, 1'b1, 1'b0);
        idle(2);

        // Restart while in PAR with a simultaneous bit: the bit is discarded.
        start();
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        send_frame(8'b11000000, 1'b0, 8'h03, 1'b0, 0, 1'b0, 1'b0);
        idle(2);

        // Restart in DATA with a simultaneous bit: 0x01 with parity 1 is good even.
        start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        frame_start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        frame_start = 1'b0; bit_valid = 1'b0;
        send_frame(8'b10000000, 1'b1, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        idle(2);

        // Saturation: 300 frames of 0x01 with parity 0 are all bad for even.
        for (int f = 0; f < 300; f++) begin
            send_frame(8'b10000000, 1'b0, 8'h01, 1'b1, 0, 1'b1, 1'b0);
        end
        idle(2);
        chk("err_count_saturated", cnt_e, 255);
        send_frame(8'b10000000, 1'b0, 8'h01, 1'b1, 0, 1'b1, 1'b0);
        idle(2);
        chk("err_count_stays_255", cnt_e, 255);

        // Asynchronous reset mid-frame, away from a clock edge.
        start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("busy_before_reset", busy_e, 1);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        mcnt_e = 0; mcnt_o = 0;
        idle(2);
        reset = 1'b0;
        idle(1);
        // A partial frame does not survive reset: these bits need a new start.
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        idle(2);
        chk_all_zero("no_frame_after_reset");
        // 0x00 with parity 1: good for odd, bad for even.
        send_frame(8'b00000000, 1'b1, 8'h00, 1'b1, 0, 1'b1, 1'b0);
        idle(5);

        chk("even_queue_drained", q_e.size(), 0);
        chk("odd_queue_drained",  q_o.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
